// File: rtl/mod6_step_source.sv
// Step-event source for the mod-6 counter: synchronised, debounced push-button
// presses plus optional periodic auto-ticks, queued in a saturating pending count.
module mod6_step_source #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int PRESCALE_W      = 16,
  parameter int PEND_W          = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  btn_raw,
  input  logic                  auto_en,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic                  step_ready,
  input  logic                  ovf_clr,
  output logic                  step_valid,
  output logic [PEND_W-1:0]     pending,
  output logic                  btn_level,
  output logic                  ovf
);

  localparam int                  NW     = PEND_W + 2;
  localparam logic [NW-1:0]       MAXV   = NW'((1 << PEND_W) - 1);
  localparam logic [7:0]          DB_TGT = 8'(DEBOUNCE_CYCLES);
  localparam logic [PRESCALE_W-1:0] PS_ONE = PRESCALE_W'(1);

  logic                  r_s1, r_s2;
  logic [7:0]            r_db_cnt;
  logic                  r_lvl, r_lvl_d, r_press;
  logic [PRESCALE_W-1:0] r_pc;
  logic [PEND_W-1:0]     r_pend;
  logic                  r_ovf;

  logic                  w_active, w_tick, w_sat;
  logic [NW-1:0]         w_inc, w_dec, w_next;

  // Two-flop synchroniser; only r_s2 is safe to use downstream.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
    end else begin
      r_s1 <= btn_raw;
      r_s2 <= r_s1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_db_cnt <= 8'd0;
      r_lvl    <= 1'b0;
    end else if (r_s2 == r_lvl) begin
      r_db_cnt <= 8'd0;
    end else if (r_db_cnt + 8'd1 == DB_TGT) begin
      r_lvl    <= ~r_lvl;
      r_db_cnt <= 8'd0;
    end else begin
      r_db_cnt <= r_db_cnt + 8'd1;
    end
  end

  // Rising edge of the debounced level becomes a single-cycle press.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_lvl_d <= 1'b0;
      r_press <= 1'b0;
    end else begin
      r_lvl_d <= r_lvl;
      r_press <= r_lvl & ~r_lvl_d;
    end
  end

  assign w_active = auto_en & (prescale != '0);
  // ">=" rather than "==" so shrinking prescale mid-count still wraps at once.
  assign w_tick   = w_active & (r_pc >= prescale - PS_ONE);

  always_ff @(posedge clk) begin
    if (!rst_n || !w_active) r_pc <= '0;
    else if (w_tick)         r_pc <= '0;
    else                     r_pc <= r_pc + PS_ONE;
  end

  assign step_valid = (r_pend != '0);
  assign w_inc  = NW'(r_press) + NW'(w_tick);
  assign w_dec  = NW'(step_valid & step_ready);
  assign w_next = NW'(r_pend) + w_inc - w_dec;
  assign w_sat  = (w_next > MAXV);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pend <= '0;
      r_ovf  <= 1'b0;
    end else begin
      r_pend <= w_sat ? MAXV[PEND_W-1:0] : w_next[PEND_W-1:0];
      if (w_sat)        r_ovf <= 1'b1;
      else if (ovf_clr) r_ovf <= 1'b0;
    end
  end

  assign pending   = r_pend;
  assign btn_level = r_lvl;
  assign ovf       = r_ovf;

endmodule
